// File: rtl/pwm_nhom3_pkg.sv
// ============================================================================
//  Module   : pwm_nhom3_pkg
//  Brief    : Shared constants, types and zone decode for the PWM block.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pwm_nhom3_pkg;

    localparam int PERIOD_CYCLES_DEF = 20;
    localparam int DUTY_INIT_DEF     = 6;
    localparam int DUTY_W            = 5;
    localparam int ZONE_RED_MAX      = 7;
    localparam int ZONE_BLUE_MIN     = 15;

    typedef logic [DUTY_W-1:0] duty_t;

    typedef enum logic [1:0] {
        ZONE_RED   = 2'd0,
        ZONE_GREEN = 2'd1,
        ZONE_BLUE  = 2'd2
    } zone_e;

    function automatic zone_e zone_of(input duty_t duty);
        if (duty <= duty_t'(ZONE_RED_MAX))
            return ZONE_RED;
        else if (duty >= duty_t'(ZONE_BLUE_MIN))
            return ZONE_BLUE;
        else
            return ZONE_GREEN;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_nhom3_if.sv
// ============================================================================
//  Module   : pwm_nhom3_if
//  Brief    : Button inputs and PWM/colour outputs of the PWM block.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pwm_nhom3_if;
    logic inc_5;
    logic dec_5;
    logic OUT;
    logic out_r;
    logic out_g;
    logic out_b;

    modport master (
        output inc_5, dec_5,
        input  OUT, out_r, out_g, out_b
    );

    modport slave (
        input  inc_5, dec_5,
        output OUT, out_r, out_g, out_b
    );
endinterface

`default_nettype wire

// File: rtl/pwm_btn_edge.sv
// ============================================================================
//  Module   : pwm_btn_edge
//  Brief    : 2-flop synchronizer plus registered rising-edge one-clock pulse.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic pulse_q;
    logic pulse_d;

    assign pulse_d = sync_q & ~prev_q;

    // Pulse is registered so it lands three clocks after the input rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

`default_nettype wire

// File: rtl/pwm_nhom3.sv
// ============================================================================
//  Module   : pwm_nhom3
//  Brief    : Button-adjustable PWM with 5 % steps and RGB duty-zone outputs.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_nhom3
    import pwm_nhom3_pkg::*;
#(
    parameter int PERIOD_CYCLES = PERIOD_CYCLES_DEF,
    parameter int DUTY_INIT     = DUTY_INIT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    pwm_nhom3_if.slave    pwm_if
);

    localparam duty_t CNT_LAST  = duty_t'(PERIOD_CYCLES - 1);
    localparam duty_t DUTY_MAX  = duty_t'(PERIOD_CYCLES);
    localparam duty_t DUTY_RST  = duty_t'(DUTY_INIT);

    logic  inc_pulse;
    logic  dec_pulse;

    duty_t cnt_q,    cnt_d;
    duty_t duty_q,   duty_d;
    duty_t active_q, active_d;
    logic  out_q,    out_d;
    logic  red_q,    red_d;
    logic  green_q,  green_d;
    logic  blue_q,   blue_d;
    zone_e zone;

    pwm_btn_edge u_inc_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (pwm_if.inc_5),
        .pulse_o (inc_pulse)
    );

    pwm_btn_edge u_dec_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (pwm_if.dec_5),
        .pulse_o (dec_pulse)
    );

    always_comb begin
        cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        // Active duty only changes at the wrap so each period is whole.
        active_d = (cnt_q == CNT_LAST) ? duty_q : active_q;

        duty_d = duty_q;
        case ({inc_pulse, dec_pulse})
            2'b10:   if (duty_q < DUTY_MAX) duty_d = duty_q + 1'b1;
            2'b01:   if (duty_q != '0)      duty_d = duty_q - 1'b1;
            default: duty_d = duty_q;
        endcase

        zone    = zone_of(active_q);
        out_d   = (cnt_q < active_q);
        // Colour outputs are registered alongside OUT so they share its zone.
        red_d   = out_d & (zone == ZONE_RED);
        green_d = out_d & (zone == ZONE_GREEN);
        blue_d  = out_d & (zone == ZONE_BLUE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            duty_q   <= DUTY_RST;
            active_q <= DUTY_RST;
            out_q    <= 1'b0;
            red_q    <= 1'b0;
            green_q  <= 1'b0;
            blue_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            active_q <= active_d;
            out_q    <= out_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
        end
    end

    assign pwm_if.OUT   = out_q;
    assign pwm_if.out_r = red_q;
    assign pwm_if.out_g = green_q;
    assign pwm_if.out_b = blue_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_nhom3.sv
// ============================================================================
//  Module   : tb_pwm_nhom3
//  Brief    : Directed self-checking bench for pwm_nhom3.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_pwm_nhom3;

    localparam int PER = 20;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

    pwm_nhom3_if bus ();

    pwm_nhom3 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_if (bus.slave)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    // Clocks since reset release; OUT at a negedge reflects count (cyc-1) mod PER.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check_vec(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    task automatic goto_start();
        int n;
        n = 0;
        @(negedge clk);
        while ((cyc % PER) != 1 && n < 3 * PER) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert ((cyc % PER) == 1) else begin
            failures++;
            $error("FAIL period_align obs=%0d exp=%0d", cyc % PER, 1);
        end
    endtask

    // zone: 0 red, 1 green, 2 blue
    task automatic check_period(input string tag, input int high, input int zone);
        logic       o;
        logic [3:0] exp;
        for (int i = 0; i < PER; i++) begin
            if (i > 0) @(negedge clk);
            o   = (i < high);
            exp = {o, o & (zone == 0), o & (zone == 1), o & (zone == 2)};
            check_vec($sformatf("%s[%0d]", tag, i),
                      {bus.OUT, bus.out_r, bus.out_g, bus.out_b}, exp);
        end
    endtask

    task automatic inc_pulses(input int n);
        for (int k = 0; k < n; k++) begin
            bus.inc_5 = 1'b1; #3;
            bus.inc_5 = 1'b0; #3;
        end
    endtask

    task automatic dec_pulses(input int n);
        for (int k = 0; k < n; k++) begin
            bus.dec_5 = 1'b1; #3;
            bus.dec_5 = 1'b0; #3;
        end
    endtask

    task automatic settle_and_check(input string tag, input int high, input int zone);
        #12;
        goto_start();
        check_period(tag, high, zone);
        goto_start();
        check_period({tag, "_b"}, high, zone);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.inc_5 = 1'b0;
        bus.dec_5 = 1'b0;

        repeat (3) @(negedge clk);
        check_vec("reset_outs", {bus.OUT, bus.out_r, bus.out_g, bus.out_b}, 4'b0000);
        rst_n = 1'b1;

        goto_start();
        check_period("init30_p0", 6, 0);
        goto_start();
        check_period("init30_p1", 6, 0);

        inc_pulses(4);
        settle_and_check("duty50", 10, 1);

        inc_pulses(8);
        settle_and_check("duty90", 18, 2);

        dec_pulses(5);
        settle_and_check("duty65", 13, 1);

        inc_pulses(25);
        settle_and_check("sat100", 20, 2);

        dec_pulses(25);
        settle_and_check("sat0", 0, 0);

        inc_pulses(1);
        settle_and_check("duty5", 1, 0);

        bus.inc_5 = 1'b1;
        bus.dec_5 = 1'b1;
        #3;
        bus.inc_5 = 1'b0;
        bus.dec_5 = 1'b0;
        #3;
        settle_and_check("both", 1, 0);

        bus.inc_5 = 1'b1;
        #100;
        bus.inc_5 = 1'b0;
        #4;
        settle_and_check("held", 2, 0);

        inc_pulses(14);
        settle_and_check("duty80", 16, 2);

        // Mid-period reset with an inc edge in flight.
        repeat (6) @(negedge clk);
        check_vec("pre_rst", {bus.OUT, bus.out_r, bus.out_g, bus.out_b}, 4'b1001);
        bus.inc_5 = 1'b1;
        @(negedge clk);
        rst_n     = 1'b0;
        bus.inc_5 = 1'b0;
        #0.4;
        check_vec("rst_mid_now", {bus.OUT, bus.out_r, bus.out_g, bus.out_b}, 4'b0000);
        repeat (3) @(negedge clk);
        check_vec("rst_mid_hold", {bus.OUT, bus.out_r, bus.out_g, bus.out_b}, 4'b0000);
        rst_n = 1'b1;

        goto_start();
        check_period("post_rst_p0", 6, 0);
        goto_start();
        check_period("post_rst_p1", 6, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pwm_nhom3.md
PWM_NHOM3 -- requirements
Module: pwm_nhom3

Interface
REQ-001 Parameter PERIOD_CYCLES, default 20, meaning: clocks per PWM period, one clock per 5 % duty step.
REQ-002 Parameter DUTY_INIT, default 6, meaning: duty in steps after reset (6 = 30 %).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 inc_5  input  1  asynchronous level input; each rising edge requests duty +5 %.
REQ-007 dec_5  input  1  asynchronous level input; each rising edge requests duty -5 %.
REQ-008 OUT  output  1  registered PWM output.
REQ-009 out_r  output  1  red channel: OUT gated by the low-duty zone.
REQ-010 out_g  output  1  green channel: OUT gated by the mid-duty zone.
REQ-011 out_b  output  1  blue channel: OUT gated by the high-duty zone.

Function
REQ-012 inc_5 and dec_5 SHALL each pass a 2-flop synchronizer and then a rising-edge detector that produces a 1-clock pulse.
- Pulse appears 3 clocks after the input rises.
- A level held high SHALL produce exactly one pulse.
REQ-013 The duty register (0..PERIOD_CYCLES, 5 bits) SHALL update on an inc or dec pulse.
- +1 on an inc pulse, saturating at 20 (100 %).
- -1 on a dec pulse, saturating at 0 (0 %).
REQ-014 Simultaneous inc and dec pulses in the same clock SHALL leave the duty unchanged.
REQ-015 A period counter SHALL count 0..PERIOD_CYCLES-1 and wrap to 0.
REQ-016 The active duty SHALL be loaded from the duty register only on the clock in which the counter wraps to 0, so every period is glitch-free.
REQ-017 OUT SHALL be high for exactly active-duty consecutive clocks from the start of each period and low for the rest of the period.
- Active duty 0: OUT is constantly low.
- Active duty 20: OUT is constantly high.
REQ-018 OUT SHALL be registered and lag the counter by one clock.
REQ-019 Colour zones SHALL be decoded from the active duty:
- red: active duty <= 7 (<= 35 %).
- green: active duty 8..14 (40..70 %).
- blue: active duty >= 15 (>= 75 %).
REQ-020 The colour output of the active zone SHALL equal OUT; the other two colour outputs SHALL be 0.

Reset
REQ-021 While rst_n = 0, the following SHALL hold asynchronously:
- counter = 0.
- duty register = active duty = DUTY_INIT.
- synchronizer and edge-detector flops = 0.
- OUT = out_r = out_g = out_b = 0.
REQ-022 After rst_n is released, the first period SHALL start with counter 0 and duty 30 %.
REQ-023 A reset asserted mid-period SHALL abort the period immediately and discard any pending inc or dec edges.

Structure
REQ-024 A shared package pwm_nhom3_pkg SHALL hold:
- PERIOD_CYCLES default, DUTY_INIT default.
- Duty width (5 bits).
- Zone thresholds (7, 15).
REQ-025 One sub-module, pwm_btn_edge (synchronizer plus rising-edge pulse), SHALL be instantiated twice, once for inc_5 and once for dec_5.
REQ-026 The counter, duty register, PWM compare and colour decode SHALL be implemented in pwm_nhom3 itself.

Verification
REQ-027 Reset, then no stimulus -> OUT repeats 6 clocks high, 14 low; out_r = OUT; out_g = out_b = 0.
REQ-028 Four inc_5 pulses (3 ns high / 3 ns low, 2 ns clock) -> from the next period boundary, OUT is 10 high / 10 low; out_g = OUT; out_r = out_b = 0.
REQ-029 Eight further inc pulses -> 90 % (18 high / 2 low) with out_b = OUT; five dec pulses -> 65 % (13 high / 7 low) with out_g = OUT.
REQ-030 25 inc pulses -> OUT constantly high (saturation at 100 %); then 25 dec pulses -> OUT constantly low, duty stays 0.
REQ-031 inc_5 and dec_5 rising together -> duty unchanged; inc_5 held high for 50 clocks -> exactly one +5 % step.
REQ-032 rst_n pulsed low mid-period at 80 % duty -> all outputs 0 immediately; after release, 30 % waveform resumes from the start of a period.
